// File: rtl/trunc_add_fixup.sv
// trunc_add_fixup: segmented adder that drops the low-segment carry, optionally repairing it in an extra FIX cycle.
module trunc_add_fixup #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         exact_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         approx_flag,
  input  logic         err_clr,
  output logic [15:0]  err_count
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q, sum_q, sum_d;
  logic           exact_q, approx_q, approx_d;
  logic [15:0]    err_q, err_d;
  logic [K:0]     low;
  logic [N-K-1:0] high;
  assign low  = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]};
  assign high = a_q[N-1:K] + b_q[N-1:K];
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    approx_d = approx_q;
    err_d    = err_q;
    case (state_q)
      IDLE: state_d = in_valid ? CALC : IDLE;
      CALC: begin
        if (low[K] && exact_q) begin
          state_d = FIX;
        end else begin
          state_d  = OUT;
          sum_d    = {high, low[K-1:0]};
          approx_d = low[K];
          err_d    = (low[K] && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        end
      end
      FIX: begin
        state_d  = OUT;
        sum_d    = {high + 1'b1, low[K-1:0]};
        approx_d = 1'b0;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
    err_d = err_clr ? 16'd0 : err_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      exact_q  <= 1'b0;
      sum_q    <= '0;
      approx_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      approx_q <= approx_d;
      err_q    <= err_d;
      if (state_q == IDLE && in_valid) begin
        a_q     <= a;
        b_q     <= b;
        exact_q <= exact_mode;
      end
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == OUT;
  assign sum         = sum_q;
  assign approx_flag = approx_q;
  assign err_count   = err_q;
endmodule

// File: tb/tb_trunc_add_fixup.sv
// tb_trunc_add_fixup: scoreboard bench; expected results queued at drive time, compared on delivery.
module tb_trunc_add_fixup;
  logic        clk = 0, rst = 1, in_valid = 0, exact_mode = 0, out_ready = 0, err_clr = 0;
  logic [31:0] a = 0, b = 0, sum;
  logic        in_ready, out_valid, approx_flag;
  logic [15:0] err_count;
  int          checks = 0, errors = 0;
  logic [15:0] err_m = 0;
  typedef struct {logic [31:0] sum; logic ap; int lat;} exp_t;
  exp_t        q[$];
  trunc_add_fixup dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .exact_mode(exact_mode), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .approx_flag(approx_flag), .err_clr(err_clr), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_txn(input logic [31:0] ta, input logic [31:0] tb, input logic em, input int hold, input logic clr);
    exp_t e;
    logic c;
    int   lat;
    c     = (int'(ta[7:0]) + int'(tb[7:0])) > 255;
    e.ap  = c && !em;
    e.sum = e.ap ? ta + tb - 32'd256 : ta + tb;
    e.lat = (c && em) ? 3 : 2;
    q.push_back(e);
    if (clr) err_m = 0;
    else if (e.ap && err_m != 16'hFFFF) err_m++;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    a = ta; b = tb; exact_mode = em; in_valid = 1;
    @(negedge clk);
    in_valid = 0; err_clr = clr; lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      err_clr = 0;
      lat++;
    end
    e = q.pop_front();
    chk("sum", sum, e.sum);
    chk("approx", 32'(approx_flag), 32'(e.ap));
    chk("latency", lat, e.lat);
    chk("err_count", 32'(err_count), 32'(err_m));
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; in_valid = 1;
      @(negedge clk);
      chk("hold_sum", sum, e.sum);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1; in_valid = 1;
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    chk("release_valid", 32'(out_valid), 0);
    chk("release_idle", 32'(in_ready), 1);
  endtask
  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", sum, 0);
    chk("rst_err", 32'(err_count), 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    run_txn(32'h000000F0, 32'h00000020, 0, 0, 0);
    run_txn(32'h000000F0, 32'h00000020, 1, 0, 0);
    run_txn(32'h12345601, 32'h00000002, 0, 0, 0);
    run_txn(32'h12345601, 32'h00000002, 1, 0, 0);
    run_txn(32'hFFFFFFFF, 32'h00000001, 1, 0, 0);
    run_txn(32'hFFFFFFFF, 32'h00000001, 0, 5, 0);
    for (int i = 0; i < 8; i++) run_txn($urandom, $urandom, 1'($urandom), i % 3, 0);
    // reset while the repair cycle is in flight
    @(negedge clk);
    a = 32'h000000F0; b = 32'h00000020; exact_mode = 1; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    err_m = 0;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_approx", 32'(approx_flag), 0);
    chk("midrst_err", 32'(err_count), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 0);
    end
    force dut.err_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_q;
    err_m = 16'hFFFF;
    chk("preload", 32'(err_count), 32'hFFFF);
    run_txn(32'h000000F0, 32'h00000020, 0, 0, 0);
    run_txn(32'h000000F0, 32'h00000020, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
